// File: rtl/komut_bellek_yanit.sv
// komut_bellek_yanit: instruction memory responder for the fetch stage.
// A boot loader first streams the program image in over yukle_* (valid/ready).
// The block then serves each new pc after GECIKME cycles with komut,
// komut_gecerli and a fault flag.
// Optional feature: define KOMUT_SAYAC_EN to add the 16-bit okuma_sayisi output.
// okuma_sayisi counts fault-free fetches and saturates at 16'hFFFF.
module komut_bellek_yanit #(
  parameter int unsigned DERINLIK  = 256,
  parameter int unsigned GECIKME   = 2,
  parameter logic [31:0] BOS_KOMUT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] komut,
  output logic        komut_gecerli,
  output logic        hata,
  input  logic        yukle_gecerli,
  input  logic [31:0] yukle_veri,
  input  logic        yukle_son,
  output logic        yukle_hazir,
  output logic        calisiyor
`ifdef KOMUT_SAYAC_EN
  ,
  output logic [15:0] okuma_sayisi
`endif
);

  localparam int AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    YUKLE,
    OKU,
    SUN
  } durum_t;

  durum_t        r_durum;
  durum_t        w_sonrakiDurum;

  logic [31:0]   r_mem [DERINLIK];
  logic [AW-1:0] r_ptr;
  logic [CW-1:0] r_yuklenen;
  logic [31:0]   r_aktifPc;
  logic [2:0]    r_sayac;
  logic [31:0]   r_sonucKomut;
  logic          r_sonucHata;

  logic          w_aktar;
  logic          w_yukleBitti;
  logic          w_pcDegisti;
  logic [AW-1:0] w_idx;
  logic          w_hizasiz;
  logic          w_aralikDisi;
  logic          w_sonucHazir;
  logic [31:0]   w_sonucKomut;
  logic          w_sonucHata;

  assign w_aktar      = (r_durum == YUKLE) && yukle_gecerli && yukle_hazir;
  assign w_yukleBitti = w_aktar && (yukle_son || (r_ptr == AW'(DERINLIK - 1)));
  assign w_pcDegisti  = (pc != r_aktifPc);
  assign w_idx        = r_aktifPc[AW+1:2];
  assign w_hizasiz    = (r_aktifPc[1:0] != 2'b00);
  assign w_aralikDisi = (r_aktifPc[31:AW+2] != '0);
  assign w_sonucHazir = (r_durum == OKU) && !w_pcDegisti && (r_sayac == 3'd0);

  // Classify the latched address: fault, unloaded bubble, or a real memory word
  always_comb begin
    w_sonucKomut = BOS_KOMUT;
    w_sonucHata  = 1'b0;
    if (w_hizasiz || w_aralikDisi) begin
      w_sonucHata = 1'b1;
    end else if ({1'b0, w_idx} < r_yuklenen) begin
      w_sonucKomut = r_mem[w_idx];
    end
  end

  // State register; reset always returns to the loader phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_durum <= YUKLE;
    end else begin
      r_durum <= w_sonrakiDurum;
    end
  end

  // Next state: load once, then alternate between waiting and serving per pc
  always_comb begin
    w_sonrakiDurum = r_durum;
    unique case (r_durum)
      YUKLE: if (w_yukleBitti) w_sonrakiDurum = OKU;
      OKU:   if (w_sonucHazir) w_sonrakiDurum = SUN;
      SUN:   if (w_pcDegisti)  w_sonrakiDurum = OKU;
      default: w_sonrakiDurum = YUKLE;
    endcase
  end

  // Outputs come from state and registered result only, never straight from pc
  always_comb begin
    komut         = BOS_KOMUT;
    komut_gecerli = 1'b0;
    hata          = 1'b0;
    calisiyor     = (r_durum != YUKLE);
    yukle_hazir   = (r_durum == YUKLE) && reset;
    if (r_durum == SUN) begin
      komut         = r_sonucKomut;
      komut_gecerli = 1'b1;
      hata          = r_sonucHata;
    end
  end

  // Loader bookkeeping, pc latch with latency restart, and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr        <= '0;
      r_yuklenen   <= '0;
      r_aktifPc    <= '0;
      r_sayac      <= '0;
      r_sonucKomut <= BOS_KOMUT;
      r_sonucHata  <= 1'b0;
    end else begin
      if (w_aktar) begin
        r_ptr      <= r_ptr + AW'(1);
        r_yuklenen <= r_yuklenen + CW'(1);
      end
      if (w_yukleBitti || ((r_durum != YUKLE) && w_pcDegisti)) begin
        r_aktifPc <= pc;
        r_sayac   <= 3'(GECIKME - 1);
      end else if (w_sonucHazir) begin
        r_sonucKomut <= w_sonucKomut;
        r_sonucHata  <= w_sonucHata;
      end else if (r_durum == OKU) begin
        r_sayac <= r_sayac - 3'd1;
      end
    end
  end

  // Program storage; deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (w_aktar) begin
      r_mem[r_ptr] <= yukle_veri;
    end
  end

`ifdef KOMUT_SAYAC_EN
  logic [15:0] r_okumaSayisi;

  // Count fault-free completed fetches, saturating at the top value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_okumaSayisi <= '0;
    end else if (w_sonucHazir && !w_sonucHata && (r_okumaSayisi != 16'hFFFF)) begin
      r_okumaSayisi <= r_okumaSayisi + 16'd1;
    end
  end

  assign okuma_sayisi = r_okumaSayisi;
`endif

endmodule

// File: tb/tb_komut_bellek_yanit.sv
// tb_komut_bellek_yanit: directed bench for komut_bellek_yanit with default
// parameters (DERINLIK=256, GECIKME=2, BOS_KOMUT=0).
module tb_komut_bellek_yanit;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] komut;
  logic        komut_gecerli;
  logic        hata;
  logic        yukle_gecerli;
  logic [31:0] yukle_veri;
  logic        yukle_son;
  logic        yukle_hazir;
  logic        calisiyor;
`ifdef KOMUT_SAYAC_EN
  logic [15:0] okuma_sayisi;
`endif

  int checks   = 0;
  int failures = 0;

  komut_bellek_yanit dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .komut         (komut),
    .komut_gecerli (komut_gecerli),
    .hata          (hata),
    .yukle_gecerli (yukle_gecerli),
    .yukle_veri    (yukle_veri),
    .yukle_son     (yukle_son),
    .yukle_hazir   (yukle_hazir),
    .calisiyor     (calisiyor)
`ifdef KOMUT_SAYAC_EN
    ,
    .okuma_sayisi  (okuma_sayisi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input logic [31:0] base, input logic sonLast,
                            output int hs);
    hs = 0;
    for (int i = 0; i < n; i++) begin
      yukle_gecerli = 1'b1;
      yukle_veri    = base + 32'(i);
      yukle_son     = sonLast && (i == n - 1);
      #1;
      if (yukle_hazir === 1'b1) hs++;
      tick;
    end
    yukle_gecerli = 1'b0;
    yukle_son     = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (komut_gecerli !== 1'b1 && cyc < 20);
    if (komut_gecerli !== 1'b1) cyc = -1;
  endtask

  task automatic do_fetch(input logic [31:0] addr, output int cyc);
    pc = addr;
    wait_valid(cyc);
  endtask

  task automatic test_reset;
    reset = 1'b0; pc = '0; yukle_gecerli = 1'b0; yukle_veri = '0; yukle_son = 1'b0;
    tick; tick;
    checks++; if (komut !== 32'h0) begin failures++; $display("[TB] FAIL reset_komut got=%h exp=%h", komut, 32'h0); end
    checks++; if (komut_gecerli !== 1'b0) begin failures++; $display("[TB] FAIL reset_gecerli got=%b exp=0", komut_gecerli); end
    checks++; if (hata !== 1'b0) begin failures++; $display("[TB] FAIL reset_hata got=%b exp=0", hata); end
    checks++; if (calisiyor !== 1'b0) begin failures++; $display("[TB] FAIL reset_calisiyor got=%b exp=0", calisiyor); end
    checks++; if (yukle_hazir !== 1'b0) begin failures++; $display("[TB] FAIL reset_hazir got=%b exp=0", yukle_hazir); end
`ifdef KOMUT_SAYAC_EN
    checks++; if (okuma_sayisi !== 16'd0) begin failures++; $display("[TB] FAIL reset_sayac got=%0d exp=0", okuma_sayisi); end
`endif
    reset = 1'b1;
    #1;
    checks++; if (yukle_hazir !== 1'b1) begin failures++; $display("[TB] FAIL release_hazir got=%b exp=1", yukle_hazir); end
    checks++; if (calisiyor !== 1'b0) begin failures++; $display("[TB] FAIL release_calisiyor got=%b exp=0", calisiyor); end
  endtask

  task automatic test_load;
    int hs;
    pc = 32'h8;
    load_words(4, 32'hA000_0001, 1'b1, hs);
    checks++; if (hs !== 4) begin failures++; $display("[TB] FAIL load_handshakes got=%0d exp=4", hs); end
    checks++; if (yukle_hazir !== 1'b0) begin failures++; $display("[TB] FAIL load_hazir_after got=%b exp=0", yukle_hazir); end
    checks++; if (calisiyor !== 1'b1) begin failures++; $display("[TB] FAIL load_calisiyor got=%b exp=1", calisiyor); end
  endtask

  task automatic test_read;
    checks++; if (komut_gecerli !== 1'b0) begin failures++; $display("[TB] FAIL read_wait1 got=%b exp=0", komut_gecerli); end
    tick;
    checks++; if (komut_gecerli !== 1'b0 || komut !== 32'h0) begin failures++; $display("[TB] FAIL read_wait2 gecerli=%b komut=%h exp 0/0", komut_gecerli, komut); end
    tick;
    checks++; if (komut_gecerli !== 1'b1) begin failures++; $display("[TB] FAIL read_valid got=%b exp=1", komut_gecerli); end
    checks++; if (komut !== 32'hA000_0003) begin failures++; $display("[TB] FAIL read_komut got=%h exp=%h", komut, 32'hA000_0003); end
    checks++; if (hata !== 1'b0) begin failures++; $display("[TB] FAIL read_hata got=%b exp=0", hata); end
    tick; tick;
    checks++; if (komut_gecerli !== 1'b1 || komut !== 32'hA000_0003) begin failures++; $display("[TB] FAIL read_hold gecerli=%b komut=%h exp 1/%h", komut_gecerli, komut, 32'hA000_0003); end
  endtask

  task automatic test_restart;
    int staleSeen;
    staleSeen = 0;
    pc = 32'h0;
    tick;
    checks++; if (komut_gecerli !== 1'b0) begin failures++; $display("[TB] FAIL restart_drop got=%b exp=0", komut_gecerli); end
    pc = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (komut_gecerli === 1'b1 && komut === 32'hA000_0001) staleSeen++;
      if (i < 2) begin
        checks++; if (komut_gecerli !== 1'b0) begin failures++; $display("[TB] FAIL restart_wait%0d got=%b exp=0", i, komut_gecerli); end
      end
    end
    checks++; if (staleSeen !== 0) begin failures++; $display("[TB] FAIL restart_stale got=%0d exp=0", staleSeen); end
    checks++; if (komut_gecerli !== 1'b1 || komut !== 32'hA000_0002) begin failures++; $display("[TB] FAIL restart_komut gecerli=%b komut=%h exp 1/%h", komut_gecerli, komut, 32'hA000_0002); end
  endtask

  task automatic test_faults;
    logic [31:0] tA [8];
    logic [31:0] tK [8];
    logic        tH [8];
    int          cyc;
    tA = '{32'h6, 32'h400, 32'h20, 32'h10, 32'h3FC, 32'h8000_0000, 32'h0, 32'hC};
    tK = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA000_0001, 32'hA000_0004};
    tH = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_fetch(tA[i], cyc);
      checks++; if (cyc !== 3) begin failures++; $display("[TB] FAIL fault_latency pc=%h got=%0d exp=3", tA[i], cyc); end
      checks++; if (komut !== tK[i]) begin failures++; $display("[TB] FAIL fault_komut pc=%h got=%h exp=%h", tA[i], komut, tK[i]); end
      checks++; if (hata !== tH[i]) begin failures++; $display("[TB] FAIL fault_hata pc=%h got=%b exp=%b", tA[i], hata, tH[i]); end
    end
  endtask

  task automatic test_reset_mid_read;
    int hs;
    int cyc;
    pc = 32'h0;
    tick;
    reset = 1'b0;
    #1;
    checks++; if (komut_gecerli !== 1'b0 || komut !== 32'h0 || hata !== 1'b0) begin failures++; $display("[TB] FAIL midreset_out gecerli=%b komut=%h hata=%b exp 0/0/0", komut_gecerli, komut, hata); end
    checks++; if (calisiyor !== 1'b0 || yukle_hazir !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ctl calisiyor=%b hazir=%b exp 0/0", calisiyor, yukle_hazir); end
`ifdef KOMUT_SAYAC_EN
    checks++; if (okuma_sayisi !== 16'd0) begin failures++; $display("[TB] FAIL midreset_sayac got=%0d exp=0", okuma_sayisi); end
`endif
    tick;
    reset = 1'b1;
    #1;
    checks++; if (yukle_hazir !== 1'b1 || calisiyor !== 1'b0) begin failures++; $display("[TB] FAIL midreset_release hazir=%b calisiyor=%b exp 1/0", yukle_hazir, calisiyor); end
    load_words(2, 32'hB000_0001, 1'b1, hs);
    checks++; if (hs !== 2) begin failures++; $display("[TB] FAIL reload_handshakes got=%0d exp=2", hs); end
    wait_valid(cyc);
    checks++; if (cyc !== 2 || komut !== 32'hB000_0001) begin failures++; $display("[TB] FAIL reload_first cyc=%0d komut=%h exp 2/%h", cyc, komut, 32'hB000_0001); end
    do_fetch(32'h4, cyc);
    checks++; if (komut !== 32'hB000_0002 || hata !== 1'b0) begin failures++; $display("[TB] FAIL reload_second komut=%h hata=%b exp %h/0", komut, hata, 32'hB000_0002); end
    do_fetch(32'h8, cyc);
    checks++; if (cyc !== 3 || komut !== 32'h0 || hata !== 1'b0) begin failures++; $display("[TB] FAIL reload_count cyc=%0d komut=%h hata=%b exp 3/0/0", cyc, komut, hata); end
    do_fetch(32'h6, cyc);
    checks++; if (hata !== 1'b1 || komut !== 32'h0) begin failures++; $display("[TB] FAIL reload_misaligned hata=%b komut=%h exp 1/0", hata, komut); end
`ifdef KOMUT_SAYAC_EN
    checks++; if (okuma_sayisi !== 16'd3) begin failures++; $display("[TB] FAIL sayac_value got=%0d exp=3", okuma_sayisi); end
`endif
  endtask

  task automatic test_full_load;
    int hs;
    int cyc;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    pc = 32'h3FC;
    load_words(256, 32'hC000_0000, 1'b0, hs);
    checks++; if (hs !== 256) begin failures++; $display("[TB] FAIL full_handshakes got=%0d exp=256", hs); end
    checks++; if (yukle_hazir !== 1'b0 || calisiyor !== 1'b1) begin failures++; $display("[TB] FAIL full_end hazir=%b calisiyor=%b exp 0/1", yukle_hazir, calisiyor); end
    yukle_gecerli = 1'b1;
    yukle_veri    = 32'hDEAD_BEEF;
    wait_valid(cyc);
    yukle_gecerli = 1'b0;
    checks++; if (cyc !== 2 || komut !== 32'hC000_00FF || hata !== 1'b0) begin failures++; $display("[TB] FAIL full_last cyc=%0d komut=%h hata=%b exp 2/%h/0", cyc, komut, hata, 32'hC000_00FF); end
    do_fetch(32'h0, cyc);
    checks++; if (komut !== 32'hC000_0000) begin failures++; $display("[TB] FAIL full_ignored komut=%h exp=%h", komut, 32'hC000_0000); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_read;
    test_restart;
    test_faults;
    test_reset_mid_read;
    test_full_load;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
